ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_perf_cnt.sv | 27 ++
 rtl/ifetch_ctrl.sv | 109 ++++++++++
 tb/tb_ifetch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and default parameters for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } ifetch_state_e;

    localparam int          XLEN_DEF        = 32;
    localparam int          IMEM_ADDR_W_DEF = 5;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Wrapping 32-bit counters for accepted instructions and backpressure cycles.
module ifetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_transfer,
    input  logic        i_stall,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_transfer) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_stall)    r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/ifetch_ctrl.sv
// PC sequencer feeding the decoder over valid/ready, with redirect and halt.
// Performance counters are built only when IFETCH_PERF_EN is defined.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               ADDR_W   = IMEM_ADDR_W_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              misalign_err,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    ifetch_state_e   r_state;
    ifetch_state_e   w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_valid;
    logic            r_misalign;

    logic w_transfer;
    logic w_redirect;
    logic w_misalign;
    logic w_fetch;

    assign w_transfer = r_valid && out_ready;
    assign w_redirect = redirect_valid && (r_state != ERR);
    assign w_misalign = w_redirect && (redirect_pc[1:0] != 2'b00);
    assign w_fetch    = (r_state == RUN) && !halt && !w_redirect
                        && (!r_valid || out_ready);

    // A redirect does not override the halt decision; it only replaces the PC.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = RUN;
            RUN:     w_state_next = halt ? HALT : RUN;
            HALT:    w_state_next = halt ? HALT : RUN;
            default: w_state_next = ERR;
        endcase
        if (w_misalign) w_state_next = ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_out_pc   <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_misalign) r_misalign <= 1'b1;
            if (w_redirect) begin
                r_pc    <= redirect_pc;
                r_valid <= 1'b0;
            end else if (w_fetch) begin
                r_instr  <= mem_rdata;
                r_out_pc <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= r_pc + XLEN'(4);
            end else if (w_transfer || r_state == ERR) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Upper PC bits are dropped on purpose: the memory aliases across the address space.
    assign mem_addr     = r_pc[ADDR_W+1:2];
    assign out_valid    = r_valid;
    assign out_instr    = r_instr;
    assign out_pc       = r_out_pc;
    assign misalign_err = r_misalign;

`ifdef IFETCH_PERF_EN
    logic w_perf_transfer;
    logic w_perf_stall;

    assign w_perf_transfer = w_transfer && !w_redirect;
    assign w_perf_stall    = r_valid && !out_ready;

    ifetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_transfer  (w_perf_transfer),
        .i_stall     (w_perf_stall),
        .o_fetch_cnt (perf_fetch_cnt),
        .o_stall_cnt (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a combinational 32-word instruction memory.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_err;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    logic [31:0] imem [32];
    int n_checks = 0;
    int n_errors = 0;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misalign_err   (misalign_err),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    assign mem_rdata = imem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem[0] = 32'h0118_8833;
        for (int i = 1; i < 32; i++) imem[i] = 32'hA000_0000 | 32'(i);

        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_err", {31'd0, misalign_err}, 32'd0);
        check("rst_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_pfetch", perf_fetch_cnt, 32'd0);
        check("rst_pstall", perf_stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tick(); // edge 1: IDLE -> RUN
        check("e1_valid", {31'd0, out_valid}, 32'd0);
        tick(); // edge 2: first fetch
        $display("first fetch: valid=%0b pc=0x%08h instr=0x%08h", out_valid, out_pc, out_instr);
        check("e2_valid", {31'd0, out_valid}, 32'd1);
        check("e2_pc", out_pc, 32'h0);
        check("e2_instr", out_instr, 32'h0118_8833);
        tick();
        check("e3_pc", out_pc, 32'h4);
        check("e3_instr", out_instr, 32'hA000_0001);
        tick();
        check("e4_pc", out_pc, 32'h8);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("stall %0d: pc=0x%08h addr=%0d", i, out_pc, mem_addr);
            check("bp_pc", out_pc, 32'h8);
            check("bp_instr", out_instr, 32'hA000_0002);
            check("bp_addr", {27'd0, mem_addr}, 32'd3);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
        end
`ifdef IFETCH_PERF_EN
        check("bp_pstall", perf_stall_cnt, 32'd3);
`else
        check("bp_pstall", perf_stall_cnt, 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        check("rel_pc", out_pc, 32'hC);
`ifdef IFETCH_PERF_EN
        check("rel_pfetch", perf_fetch_cnt, 32'd3);
`else
        check("rel_pfetch", perf_fetch_cnt, 32'd0);
`endif

        // redirect while the held instruction is backpressured
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("rd_flush", {31'd0, out_valid}, 32'd0);
        check("rd_addr", {27'd0, mem_addr}, 32'd16);
        tick();
        $display("redirect: valid=%0b pc=0x%08h", out_valid, out_pc);
        check("rd_valid", {31'd0, out_valid}, 32'd1);
        check("rd_pc", out_pc, 32'h40);
        check("rd_instr", out_instr, 32'hA000_0010);

        // wrap into memory alias
        redirect_valid = 1'b1; redirect_pc = 32'h7C;
        tick();
        redirect_valid = 1'b0;
        check("al_addr31", {27'd0, mem_addr}, 32'd31);
        tick();
        check("al_pc7c", out_pc, 32'h7C);
        check("al_instr31", out_instr, 32'hA000_001F);
        check("al_addr0", {27'd0, mem_addr}, 32'd0);
        tick();
        check("al_pc80", out_pc, 32'h80);
        check("al_instr0", out_instr, 32'h0118_8833);

        // PC wraps modulo 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wr_pcmax", out_pc, 32'hFFFF_FFFC);
        tick();
        check("wr_pc0", out_pc, 32'h0);

        // halt and redirect together
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check("hr_valid", {31'd0, out_valid}, 32'd0);
        check("hr_addr", {27'd0, mem_addr}, 32'd4);
        tick();
        check("hr_hold_valid", {31'd0, out_valid}, 32'd0);
        check("hr_hold_addr", {27'd0, mem_addr}, 32'd4);
        halt = 1'b0;
        tick();
        check("hr_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        $display("resume: valid=%0b pc=0x%08h", out_valid, out_pc);
        check("hr_e2_valid", {31'd0, out_valid}, 32'd1);
        check("hr_e2_pc", out_pc, 32'h10);
        check("hr_e2_instr", out_instr, 32'hA000_0004);

        // pending instruction survives halt, drains without refill
        out_ready = 1'b0; halt = 1'b1;
        tick();
        check("hp_valid", {31'd0, out_valid}, 32'd1);
        check("hp_pc", out_pc, 32'h10);
        out_ready = 1'b1;
        tick();
        check("hp_drain", {31'd0, out_valid}, 32'd0);
        halt = 1'b0;
        tick();
        check("hp_e1", {31'd0, out_valid}, 32'd0);
        tick();
        check("hp_e2_pc", out_pc, 32'h14);
        check("hp_e2_valid", {31'd0, out_valid}, 32'd1);

        // misaligned redirect locks into ERR
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        $display("misalign: err=%0b valid=%0b", misalign_err, out_valid);
        check("ma_err", {31'd0, misalign_err}, 32'd1);
        check("ma_valid", {31'd0, out_valid}, 32'd0);
        check("ma_addr", {27'd0, mem_addr}, 32'd16);
        tick();
        check("ma_stay", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        check("ma_ign_addr", {27'd0, mem_addr}, 32'd16);
        check("ma_ign_err", {31'd0, misalign_err}, 32'd1);
        tick();
        check("ma_ign_valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_err", {31'd0, misalign_err}, 32'd0);
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_pc", out_pc, 32'd0);
        check("ar_instr", out_instr, 32'd0);
        check("ar_addr", {27'd0, mem_addr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
